pc_call_sequencer: RTL and testbench

- Parametrised next-generation program counter for the 8-bit CPU control path.
- Adds three features to the single load/count PC:
  - a configurable address width
  - signed relative branching
  - a hardware return-address stack (call/return) with overflow and underflow detection
- Sits between the control unit, which asserts one command per instruction-execute T-state, and the memory address register, which is fed by the address output.

---
 rtl/pc_call_sequencer_if.sv | 55 +++++
 rtl/pc_call_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_call_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pc_call_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_call_sequencer_if
// Command and status bundle between the control unit and the program counter /
// return-address stack.
//
// Command strobes (control unit -> sequencer), one per execute T-state:
//   i_count, i_load, i_branch, i_call, i_ret, i_clear_fault,
//   i_jump_address [ADDR_W], i_offset [ADDR_W]
// Status (sequencer -> control unit / MAR), all registered or decoded from
// registered state:
//   o_address [ADDR_W], o_stack_level [DEPTH_W], o_stack_full, o_stack_empty,
//   o_overflow, o_underflow
//
// Strobe semantics: there is no valid/ready pair. A strobe that is high at a
// rising clk edge is consumed at that edge, and the sequencer always accepts
// it. When several strobes are high together, the sequencer acts only on the
// highest-priority one: ret > call > load > branch > count. Its effect appears
// on the status outputs after that edge.
// ----------------------------------------------------------------------------
interface pc_call_sequencer_if #(
   parameter int ADDR_W  = 16,
   parameter int DEPTH_W = 3
);
   logic              i_count;
   logic              i_load;
   logic              i_branch;
   logic              i_call;
   logic              i_ret;
   logic              i_clear_fault;
   logic [ADDR_W-1:0] i_jump_address;
   logic [ADDR_W-1:0] i_offset;

   logic [ADDR_W-1:0]  o_address;
   logic [DEPTH_W-1:0] o_stack_level;
   logic               o_stack_full;
   logic               o_stack_empty;
   logic               o_overflow;
   logic               o_underflow;

   // Control unit side.
   modport master (
      output i_count, i_load, i_branch, i_call, i_ret, i_clear_fault,
             i_jump_address, i_offset,
      input  o_address, o_stack_level, o_stack_full, o_stack_empty,
             o_overflow, o_underflow
   );

   // Program counter side.
   modport slave (
      input  i_count, i_load, i_branch, i_call, i_ret, i_clear_fault,
             i_jump_address, i_offset,
      output o_address, o_stack_level, o_stack_full, o_stack_empty,
             o_overflow, o_underflow
   );
endinterface

// File: rtl/pc_call_sequencer.sv
// ----------------------------------------------------------------------------
// pc_call_sequencer
// Program counter for the 8-bit CPU control path. It supports:
//   - count
//   - absolute load
//   - signed relative branch
//   - call/return through a hardware return-address stack, with sticky
//     overflow and underflow flags
//
// Ports:
//   i_clk     : system clock; every state change happens on the rising edge
//   i_clear_n : synchronous active-low reset. It overrides any command.
//   bus       : pc_call_sequencer_if.slave. It carries the command strobes and
//               the status outputs (address, stack level/full/empty, flags).
// ----------------------------------------------------------------------------
module pc_call_sequencer #(
   parameter int                ADDR_W       = 16,
   parameter int                STACK_DEPTH  = 4,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter int                DEPTH_W      = 3
) (
   input logic                i_clk,
   input logic                i_clear_n,
   pc_call_sequencer_if.slave bus
);

   // Width of a stack slot index. A depth of 1 still needs a 1-bit index.
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [DEPTH_W-1:0] LVL_FULL = DEPTH_W'(STACK_DEPTH);

   logic [ADDR_W-1:0]  r_address;
   logic [DEPTH_W-1:0] r_level;
   logic               r_overflow;
   logic               r_underflow;
   logic [ADDR_W-1:0]  r_stack [0:STACK_DEPTH-1];

   logic               w_full;
   logic               w_empty;
   logic [IDX_W-1:0]   w_push_idx;
   logic [IDX_W-1:0]   w_pop_idx;
   logic [ADDR_W-1:0]  w_ret_addr;

   logic [ADDR_W-1:0]  w_address_nxt;
   logic [DEPTH_W-1:0] w_level_nxt;
   logic               w_push;
   logic               w_ovf_set;
   logic               w_unf_set;

   assign w_full     = (r_level == LVL_FULL);
   assign w_empty    = (r_level == '0);
   // The push slot is the current level and the pop slot is the level minus 1.
   // Each index is used only when its operation is legal, so truncating to
   // IDX_W bits is safe.
   assign w_push_idx = IDX_W'(r_level);
   assign w_pop_idx  = IDX_W'(r_level - DEPTH_W'(1));
   assign w_ret_addr = r_address + ADDR_W'(1);

   // Next-state decode. The if/else chain below encodes the command priority.
   always_comb begin
      w_address_nxt = r_address;
      w_level_nxt   = r_level;
      w_push        = 1'b0;
      w_ovf_set     = 1'b0;
      w_unf_set     = 1'b0;
      if (bus.i_ret) begin
         if (w_empty) begin
            w_unf_set = 1'b1;
         end else begin
            w_address_nxt = r_stack[w_pop_idx];
            w_level_nxt   = r_level - DEPTH_W'(1);
         end
      end else if (bus.i_call) begin
         if (w_full) begin
            // A call on a full stack is refused outright: no push and no jump.
            w_ovf_set = 1'b1;
         end else begin
            w_push        = 1'b1;
            w_address_nxt = bus.i_jump_address;
            w_level_nxt   = r_level + DEPTH_W'(1);
         end
      end else if (bus.i_load) begin
         w_address_nxt = bus.i_jump_address;
      end else if (bus.i_branch) begin
         // A modulo add of a two's-complement offset handles both directions.
         w_address_nxt = r_address + bus.i_offset;
      end else if (bus.i_count) begin
         w_address_nxt = r_address + ADDR_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_clear_n) begin
         r_address   <= RESET_VECTOR;
         r_level     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_address   <= w_address_nxt;
         r_level     <= w_level_nxt;
         // If a new fault and clear_fault arrive in the same cycle, the new
         // fault wins and the flag stays set.
         r_overflow  <= w_ovf_set | (r_overflow  & ~bus.i_clear_fault);
         r_underflow <= w_unf_set | (r_underflow & ~bus.i_clear_fault);
      end
   end

   // Stack storage is not reset. A push is suppressed during reset so that a
   // call coinciding with clear_n has no effect.
   always_ff @(posedge i_clk) begin
      if (i_clear_n && w_push) begin
         r_stack[w_push_idx] <= w_ret_addr;
      end
   end

   assign bus.o_address     = r_address;
   assign bus.o_stack_level = r_level;
   assign bus.o_stack_full  = w_full;
   assign bus.o_stack_empty = w_empty;
   assign bus.o_overflow    = r_overflow;
   assign bus.o_underflow   = r_underflow;

endmodule

// File: tb/tb_pc_call_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_call_sequencer
// Directed testbench for pc_call_sequencer with ADDR_W=16, STACK_DEPTH=4 and
// RESET_VECTOR=0. Each step drives one set of command strobes for one clock
// edge, then checks the registered outputs 1 ns after that edge. An expected
// queue records return addresses as calls push them. Returns must come back
// in reverse order.
// ----------------------------------------------------------------------------
module tb_pc_call_sequencer;

   localparam int ADDR_W  = 16;
   localparam int DEPTH_W = 3;

   // Command bit masks; combine them with '|' to build a step.
   localparam logic [5:0] CNT  = 6'b000001;
   localparam logic [5:0] BR   = 6'b000010;
   localparam logic [5:0] LD   = 6'b000100;
   localparam logic [5:0] CALL = 6'b001000;
   localparam logic [5:0] RET  = 6'b010000;
   localparam logic [5:0] CLRF = 6'b100000;
   localparam logic [5:0] NONE = 6'b000000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic clear_n;
   always #5 clk = ~clk;

   pc_call_sequencer_if #(.ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W)) bus ();

   pc_call_sequencer #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (4),
      .RESET_VECTOR(16'h0000),
      .DEPTH_W     (DEPTH_W)
   ) dut (
      .i_clk    (clk),
      .i_clear_n(clear_n),
      .bus      (bus)
   );

   // ---------------- scoreboard ----------------
   int                n_tests = 0;
   int                n_fail  = 0;
   logic [ADDR_W-1:0] exp_q[$];
   logic [ADDR_W-1:0] exp_ret;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_state(input string tag, input logic [15:0] addr,
                               input int lvl, input logic ovf, input logic unf);
      chk({tag, "/addr"},  bus.o_address, addr);
      chk({tag, "/level"}, 16'(bus.o_stack_level), 16'(lvl));
      chk({tag, "/empty"}, 16'(bus.o_stack_empty), (lvl == 0) ? 16'd1 : 16'd0);
      chk({tag, "/full"},  16'(bus.o_stack_full),  (lvl == 4) ? 16'd1 : 16'd0);
      chk({tag, "/ovf"},   16'(bus.o_overflow),  16'(ovf));
      chk({tag, "/unf"},   16'(bus.o_underflow), 16'(unf));
   endtask

   // ---------------- driver ----------------
   task automatic set_cmd(input logic [5:0] c, input logic [15:0] ja, input logic [15:0] off);
      bus.i_count        = c[0];
      bus.i_branch       = c[1];
      bus.i_load         = c[2];
      bus.i_call         = c[3];
      bus.i_ret          = c[4];
      bus.i_clear_fault  = c[5];
      bus.i_jump_address = ja;
      bus.i_offset       = off;
   endtask

   // Present one command for exactly one rising edge. Outputs are then
   // stable for sampling.
   task automatic cmd(input logic [5:0] c, input logic [15:0] ja = 16'h0,
                      input logic [15:0] off = 16'h0);
      set_cmd(c, ja, off);
      @(posedge clk);
      #1;
      set_cmd(NONE, 16'h0, 16'h0);
   endtask

   // Call that also records the expected return address.
   task automatic push_call(input logic [15:0] cur, input logic [15:0] target);
      exp_q.push_back(cur + 16'h1);
      cmd(CALL, target);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      clear_n = 1'b0;
      set_cmd(NONE, 16'h0, 16'h0);
      @(posedge clk);
      #1;
      clear_n = 1'b1;
      expect_state("reset", 16'h0000, 0, 1'b0, 1'b0);

      // Load followed by counting.
      cmd(LD, 16'h00A5);  expect_state("load_a5", 16'h00A5, 0, 1'b0, 1'b0);
      cmd(CNT);           chk("cnt1", bus.o_address, 16'h00A6);
      cmd(CNT);           chk("cnt2", bus.o_address, 16'h00A7);
      cmd(CNT);           chk("cnt3", bus.o_address, 16'h00A8);
      cmd(NONE);          chk("idle_hold", bus.o_address, 16'h00A8);

      // Wrap-around and signed branches.
      cmd(LD, 16'hFFFE);  chk("load_fffe", bus.o_address, 16'hFFFE);
      cmd(CNT);           chk("wrap1", bus.o_address, 16'hFFFF);
      cmd(CNT);           chk("wrap2", bus.o_address, 16'h0000);
      cmd(CNT);           chk("wrap3", bus.o_address, 16'h0001);
      cmd(BR, 16'h0, 16'hFFFC); chk("br_neg", bus.o_address, 16'hFFFD);
      cmd(BR, 16'h0, 16'h0010); chk("br_pos", bus.o_address, 16'h000D);

      // Nested calls and returns.
      cmd(LD, 16'h0100);
      cmd(CALL, 16'h0200); expect_state("call1", 16'h0200, 1, 1'b0, 1'b0);
      cmd(CALL, 16'h0300); expect_state("call2", 16'h0300, 2, 1'b0, 1'b0);
      cmd(RET);            expect_state("ret2",  16'h0201, 1, 1'b0, 1'b0);
      cmd(RET);            expect_state("ret1",  16'h0101, 0, 1'b0, 1'b0);

      // Fill the stack, then overflow it.
      push_call(16'h0101, 16'h1000);
      push_call(16'h1000, 16'h2000);
      push_call(16'h2000, 16'h3000);
      push_call(16'h3000, 16'h4000);
      expect_state("fill4", 16'h4000, 4, 1'b0, 1'b0);
      cmd(CALL, 16'h0ABC); expect_state("ovf_call", 16'h4000, 4, 1'b1, 1'b0);
      cmd(CLRF);           expect_state("clr_ovf",  16'h4000, 4, 1'b0, 1'b0);
      for (int i = 3; i >= 0; i--) begin
         cmd(RET);
         exp_ret = exp_q.pop_back();
         expect_state($sformatf("lifo_ret%0d", i), exp_ret, i, 1'b0, 1'b0);
      end

      // Underflow, and set-over-clear precedence.
      cmd(RET);        expect_state("unf_ret",   16'h0102, 0, 1'b0, 1'b1);
      cmd(RET | CLRF); expect_state("unf_set_wins", 16'h0102, 0, 1'b0, 1'b1);
      cmd(CLRF);       expect_state("clr_unf",   16'h0102, 0, 1'b0, 1'b0);

      // Command priority.
      cmd(CALL | LD | CNT, 16'h0500);
      expect_state("prio_call", 16'h0500, 1, 1'b0, 1'b0);
      cmd(RET | CALL, 16'h0700);
      expect_state("prio_ret", 16'h0103, 0, 1'b0, 1'b0);
      cmd(LD | BR | CNT, 16'h0222, 16'h0010);
      chk("prio_load", bus.o_address, 16'h0222);
      cmd(BR | CNT, 16'h0, 16'h0003);
      chk("prio_branch", bus.o_address, 16'h0225);
      cmd(CNT);
      chk("cnt_after", bus.o_address, 16'h0226);

      // Build up level 3 with both flags set, then reset during a call.
      cmd(RET);  expect_state("pre_unf", 16'h0226, 0, 1'b0, 1'b1);
      cmd(CALL, 16'h1000);
      cmd(CALL, 16'h2000);
      cmd(CALL, 16'h3000);
      cmd(CALL, 16'h4000);
      cmd(CALL, 16'h0ABC); expect_state("pre_ovf", 16'h4000, 4, 1'b1, 1'b1);
      cmd(RET);            expect_state("pre_lvl3", 16'h3001, 3, 1'b1, 1'b1);
      clear_n = 1'b0;
      cmd(CALL, 16'h0555);
      clear_n = 1'b1;
      expect_state("reset_mid", 16'h0000, 0, 1'b0, 1'b0);
      cmd(CNT);  chk("post_reset_cnt", bus.o_address, 16'h0001);
      cmd(RET);  expect_state("post_reset_empty", 16'h0001, 0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
